// File: rtl/conv3x3_sched_if.sv
// -----------------------------------------------------------------------------
// conv3x3_sched_if
//
// Bundles every non-clock signal of the 3x3 convolution sequencer: the run
// control (start/kernel/busy/done), the input-memory read port, the window
// presented to the combinational datapath with its result, and the
// valid/ready output-memory write port.
//
// Modports:
//   master - the sequencer (drives control status, reads, window, writes)
//   slave  - the environment (input memory, datapath, output memory, host)
//
// Signals:
//   start      host -> seq    one-cycle run request
//   kernel     host -> seq    9 int8 weights, byte k = weight k (k = ky*3+kx)
//   busy       seq  -> host   run in progress
//   done       seq  -> host   one-cycle pulse at the end of a run
//   rd_en      seq  -> mem    input-memory read strobe
//   rd_addr    seq  -> mem    input-memory address
//   rd_data    mem  -> seq    read data, one cycle after rd_en
//   win_data   seq  -> dp     packed 3x3 window, byte k = pixel k
//   win_weight seq  -> dp     latched kernel
//   ans_in     dp   -> seq    saturated int8 result
//   wr_valid   seq  -> omem   write request
//   wr_ready   omem -> seq    write accepted when high with wr_valid
//   wr_addr    seq  -> omem   output address
//   wr_data    seq  -> omem   output value
// -----------------------------------------------------------------------------
interface conv3x3_sched_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [71:0]       kernel;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [71:0]       win_data;
  logic [71:0]       win_weight;
  logic [7:0]        ans_in;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  start, kernel, rd_data, ans_in, wr_ready,
    output busy, done, rd_en, rd_addr, win_data, win_weight,
           wr_valid, wr_addr, wr_data
  );

  modport slave (
    output start, kernel, rd_data, ans_in, wr_ready,
    input  busy, done, rd_en, rd_addr, win_data, win_weight,
           wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/conv3x3_sched.sv
// -----------------------------------------------------------------------------
// conv3x3_sched
//
// Sequencer for a combinational 3x3 int8 convolution datapath. Walks a
// row-major IMG_W x IMG_H feature map held in a synchronous-read SRAM,
// fetching the nine pixels of each valid-only 3x3 window one per cycle,
// presents the window and the latched kernel to the datapath, and writes each
// result to an (IMG_H-2) x (IMG_W-2) output map through a valid/ready port.
//
// Per output pixel: 9 FETCH + WAIT + CALC + WRITE (+1 per wr_ready-low cycle).
//
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - conv3x3_sched_if.master (control, read port, window, write port)
// -----------------------------------------------------------------------------
module conv3x3_sched #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  conv3x3_sched_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LAST_C_A = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LAST_R_A = ADDR_W'(IMG_H - 3);
  localparam logic [3:0]        K_LAST   = 4'd8;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d;        // output row of the current window
  logic [ADDR_W-1:0] c_q, c_d;        // output column of the current window
  logic [3:0]        k_q, k_d;        // window slot being fetched
  logic              cap_en_q;        // a read was issued last cycle
  logic [3:0]        cap_slot_q;      // slot that read belongs to
  logic [71:0]       win_data_q;
  logic [71:0]       win_weight_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              rd_en;
  logic              start_ok;
  logic              wr_accept;
  logic              last_pix;
  logic [1:0]        ky, kx;
  logic [ADDR_W-1:0] fetch_addr;

  assign start_ok  = (state_q == S_IDLE) && bus.start;
  assign wr_accept = (state_q == S_WRITE) && bus.wr_ready;
  assign last_pix  = (r_q == LAST_R_A) && (c_q == LAST_C_A);
  assign rd_en     = (state_q == S_FETCH);

  // Split slot k into window row/column (k/3, k%3) without a divider.
  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    ky = 2'd0;
    kx = 2'd0;
    if (k_q >= 4'd6) begin
      ky = 2'd2;
      kx = 2'(k_q - 4'd6);
    end else if (k_q >= 4'd3) begin
      ky = 2'd1;
      kx = 2'(k_q - 4'd3);
    end else begin
      kx = k_q[1:0];
    end
  end

  // Unsigned, truncated to ADDR_W; the map is guaranteed to fit.
  assign fetch_addr = (r_q + ADDR_W'(ky)) * IMG_W_A + c_q + ADDR_W'(kx);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (k_q == K_LAST) begin
          state_d = S_WAIT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end

      // Slot 8 lands during this cycle; the window is complete after it.
      S_WAIT: state_d = S_CALC;

      S_CALC: begin
        wr_data_d = bus.ans_in;
        wr_addr_d = r_q * OUT_W_A + c_q;
        state_d   = S_WRITE;
      end

      // wr_addr/wr_data are registers, so they stay put while wr_ready is low.
      S_WRITE: begin
        if (bus.wr_ready) begin
          if (c_q == LAST_C_A) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            k_d     = '0;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      cap_en_q     <= 1'b0;
      cap_slot_q   <= '0;
      // NOTE: the window is a 72-bit register bank, not a RAM, so it can take
      // a reset and present a defined value to the datapath after reset.
      win_data_q   <= '0;
      win_weight_q <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;

      // Read data arrives one cycle after its strobe: remember which slot
      // the strobe was for and store the byte on the following edge.
      cap_en_q   <= rd_en;
      cap_slot_q <= k_q;
      if (cap_en_q) begin
        win_data_q[{cap_slot_q, 3'b000} +: 8] <= bus.rd_data;
      end

      if (start_ok) begin
        win_weight_q <= bus.kernel;
      end
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_en ? fetch_addr : '0;
  assign bus.win_data   = win_data_q;
  assign bus.win_weight = win_weight_q;
  assign bus.wr_valid   = (state_q == S_WRITE);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_conv3x3_sched.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_sched
//
// Drives two sequencer instances (3x3 map and 5x4 map), each with a
// synchronous-read input memory, a behavioural datapath and an output port
// whose wr_ready is steered by the test tasks.
// -----------------------------------------------------------------------------
module tb_conv3x3_sched;

  logic clk  = 1'b0;
  logic rst3 = 1'b1;
  logic rst5 = 1'b1;

  always #5 clk = ~clk;

  conv3x3_sched_if #(.ADDR_W(16)) bus3 ();
  conv3x3_sched_if #(.ADDR_W(16)) bus5 ();

  conv3x3_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(16)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  conv3x3_sched #(.IMG_W(5), .IMG_H(4), .ADDR_W(16)) dut5 (
    .clk (clk),
    .rst (rst5),
    .bus (bus5)
  );

  logic [7:0] mem3 [0:8];
  logic [7:0] mem5 [0:19];

  always @(posedge clk) begin
    if (bus3.rd_en) bus3.rd_data <= mem3[int'(bus3.rd_addr)];
    if (bus5.rd_en) bus5.rd_data <= mem5[int'(bus5.rd_addr)];
  end

  // Datapath: sum of nine signed products, arithmetic >>8, saturate to int8.
  function automatic logic [7:0] dp(input logic [71:0] d, input logic [71:0] w);
    int acc;
    int p;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      p   = int'($signed(d[8*k +: 8])) * int'($signed(w[8*k +: 8]));
      acc = acc + p;
    end
    acc = acc >>> 8;
    if (acc > 127)  return 8'h7f;
    if (acc < -128) return 8'h80;
    return acc[7:0];
  endfunction

  assign bus3.ans_in = dp(bus3.win_data, bus3.win_weight);
  assign bus5.ans_in = dp(bus5.win_data, bus5.win_weight);

  localparam logic [71:0] K_ALL10 = {9{8'h10}};
  localparam logic [71:0] K_ALL7F = {9{8'h7f}};
  localparam logic [71:0] K_ID    = {32'h0, 8'h7f, 32'h0};

  int errors = 0;
  int checks = 0;

  // Results of the most recent run.
  logic [15:0] wa [0:15];
  logic [7:0]  wd [0:15];
  logic [71:0] ww [0:15];
  logic [15:0] rdseq [0:8];
  int nw, ndone, cyc_done, post_busy, post_done, nrd, held_bad, stall_seen;
  bit timeout;

  // 5x4 map with pixel = index and the identity kernel: out = (centre*127)>>8.
  function automatic logic [7:0] exp_data5(input int i);
    case (i)
      0: return 8'd2;   // centre 6
      1: return 8'd3;   // centre 7
      2: return 8'd3;   // centre 8
      3: return 8'd5;   // centre 11
      4: return 8'd5;   // centre 12
      default: return 8'd6;  // centre 13
    endcase
  endfunction

  function automatic logic [71:0] exp_win5(input int i);
    logic [71:0] v;
    int r, c;
    r = i / 3;
    c = i % 3;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'((r + k / 3) * 5 + c + k % 3);
    return v;
  endfunction

  task automatic clear_results();
    nw = 0; ndone = 0; cyc_done = 0; post_busy = 0; post_done = 0;
    nrd = 0; held_bad = 0; stall_seen = 0; timeout = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wa[i] = 'x; wd[i] = 'x; ww[i] = 'x;
    end
    for (int i = 0; i < 9; i++) rdseq[i] = 'x;
  endtask

  task automatic run3(input logic [71:0] kern);
    int cnt;
    clear_results();
    @(negedge clk);
    bus3.kernel = kern; bus3.start = 1'b1; bus3.wr_ready = 1'b1; cnt = 1;
    @(negedge clk);
    bus3.start = 1'b0; cnt = 2;
    while (1) begin
      if (bus3.wr_valid && bus3.wr_ready) begin
        if (nw < 16) begin
          wa[nw] = bus3.wr_addr; wd[nw] = bus3.wr_data; ww[nw] = bus3.win_data;
        end
        nw++;
      end
      if (bus3.done) begin ndone++; cyc_done = cnt; end
      if (ndone != 0 || cnt >= 300) break;
      @(negedge clk); cnt++;
    end
    timeout = (ndone == 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus3.busy) post_busy++;
      if (bus3.done) post_done++;
    end
  endtask

  // stall_idx: write index held off for stall_len cycles (-1: none).
  // spam: pulse start with a different kernel mid-run and in the DONE cycle.
  task automatic run5(input logic [71:0] kern, input int stall_idx,
                      input int stall_len, input bit spam);
    int cnt, scnt;
    logic [15:0] ha;
    logic [7:0]  hd;
    clear_results();
    scnt = 0; ha = '0; hd = '0;
    @(negedge clk);
    bus5.kernel = kern; bus5.start = 1'b1; bus5.wr_ready = 1'b1; cnt = 1;
    @(negedge clk);
    bus5.start = 1'b0; cnt = 2;
    while (1) begin
      if (bus5.rd_en && nrd < 9) begin rdseq[nrd] = bus5.rd_addr; nrd++; end
      if (spam && cnt == 20) begin
        bus5.start = 1'b1; bus5.kernel = ~kern;
      end else if (spam && cnt == 21) begin
        bus5.start = 1'b0;
      end
      if (bus5.wr_valid) begin
        if (nw == stall_idx && scnt < stall_len) begin
          if (scnt == 0) begin
            ha = bus5.wr_addr; hd = bus5.wr_data;
          end else if (bus5.wr_addr !== ha || bus5.wr_data !== hd) begin
            held_bad++;
          end
          bus5.wr_ready = 1'b0; scnt++; stall_seen++;
        end else begin
          if (nw == stall_idx && scnt > 0 && (bus5.wr_addr !== ha || bus5.wr_data !== hd))
            held_bad++;
          bus5.wr_ready = 1'b1;
          if (nw < 16) begin
            wa[nw] = bus5.wr_addr; wd[nw] = bus5.wr_data; ww[nw] = bus5.win_data;
          end
          nw++;
        end
      end else begin
        if (nw == stall_idx && scnt > 0 && scnt < stall_len) held_bad++;
        bus5.wr_ready = 1'b1;
      end
      if (bus5.done) begin
        ndone++; cyc_done = cnt;
        if (spam) bus5.start = 1'b1;
      end
      if (ndone != 0 || cnt >= 400) break;
      @(negedge clk); cnt++;
    end
    timeout = (ndone == 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) bus5.start = 1'b0;
      if (bus5.busy) post_busy++;
      if (bus5.done) post_done++;
    end
  endtask

  task automatic test_reset();
    rst3 = 1'b1; rst5 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus5.busy, bus5.done, bus5.rd_en, bus5.wr_valid} !== 4'b0)
      $display("FAIL reset_flags5: got %b expected 0000",
               {bus5.busy, bus5.done, bus5.rd_en, bus5.wr_valid});
    if ({bus5.busy, bus5.done, bus5.rd_en, bus5.wr_valid} !== 4'b0) errors++;
    checks++;
    if (bus5.rd_addr !== 16'd0 || bus5.wr_addr !== 16'd0 || bus5.wr_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_addr5: got rd=%0h wa=%0h wd=%0h expected 0", bus5.rd_addr,
               bus5.wr_addr, bus5.wr_data);
    end
    checks++;
    if (bus5.win_data !== 72'd0 || bus5.win_weight !== 72'd0) begin
      errors++;
      $display("FAIL reset_win5: got %h / %h expected 0", bus5.win_data, bus5.win_weight);
    end
    checks++;
    if ({bus3.busy, bus3.done, bus3.rd_en, bus3.wr_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags3: got %b expected 0000",
               {bus3.busy, bus3.done, bus3.rd_en, bus3.wr_valid});
    end
    rst3 = 1'b0; rst5 = 1'b0;
  endtask

  task automatic test_single_pixel();
    for (int i = 0; i < 9; i++) mem3[i] = 8'h10;
    run3(K_ALL10);
    checks++;
    if (timeout) begin errors++; $display("FAIL single_timeout: no done within budget"); end
    checks++;
    if (nw != 1) begin errors++; $display("FAIL single_nwrites: got %0d expected 1", nw); end
    checks++;
    if (wa[0] !== 16'd0) begin errors++; $display("FAIL single_addr: got %0h expected 0", wa[0]); end
    checks++;
    if (wd[0] !== 8'd9) begin errors++; $display("FAIL single_data: got %0h expected 9", wd[0]); end
    checks++;
    if (cyc_done != 14) begin errors++; $display("FAIL single_cycles: got %0d expected 14", cyc_done); end
    checks++;
    if (ndone + post_done != 1) begin
      errors++; $display("FAIL single_done_count: got %0d expected 1", ndone + post_done);
    end
    checks++;
    if (post_busy != 0) begin errors++; $display("FAIL single_busy_after: got %0d expected 0", post_busy); end
    checks++;
    if (bus3.win_weight !== K_ALL10) begin
      errors++; $display("FAIL single_weight: got %h expected %h", bus3.win_weight, K_ALL10);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] pix [0:1];
    logic [7:0] expv [0:1];
    pix[0] = 8'h7f; expv[0] = 8'h7f;
    pix[1] = 8'h80; expv[1] = 8'h80;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 9; i++) mem3[i] = pix[t];
      run3(K_ALL7F);
      checks++;
      if (nw != 1 || timeout) begin
        errors++; $display("FAIL sat_nwrites[%0d]: got %0d expected 1", t, nw);
      end
      checks++;
      if (wd[0] !== expv[t]) begin
        errors++; $display("FAIL sat_data[%0d]: got %0h expected %0h", t, wd[0], expv[t]);
      end
      checks++;
      if (ww[0] !== {9{pix[t]}}) begin
        errors++; $display("FAIL sat_window[%0d]: got %h expected %h", t, ww[0], {9{pix[t]}});
      end
    end
  endtask

  task automatic test_5x4_identity();
    logic [15:0] exp_rd [0:8];
    exp_rd[0] = 16'd0;  exp_rd[1] = 16'd1;  exp_rd[2] = 16'd2;
    exp_rd[3] = 16'd5;  exp_rd[4] = 16'd6;  exp_rd[5] = 16'd7;
    exp_rd[6] = 16'd10; exp_rd[7] = 16'd11; exp_rd[8] = 16'd12;
    run5(K_ID, -1, 0, 1'b0);
    checks++;
    if (timeout || nw != 6) begin errors++; $display("FAIL id_nwrites: got %0d expected 6", nw); end
    checks++;
    if (cyc_done != 74) begin errors++; $display("FAIL id_cycles: got %0d expected 74", cyc_done); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rdseq[i] !== exp_rd[i]) begin
        errors++; $display("FAIL id_rd_addr[%0d]: got %0d expected %0d", i, rdseq[i], exp_rd[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wa[i] !== 16'(i)) begin errors++; $display("FAIL id_wr_addr[%0d]: got %0d expected %0d", i, wa[i], i); end
      checks++;
      if (wd[i] !== exp_data5(i)) begin
        errors++; $display("FAIL id_wr_data[%0d]: got %0d expected %0d", i, wd[i], exp_data5(i));
      end
      checks++;
      if (ww[i] !== exp_win5(i)) begin
        errors++; $display("FAIL id_window[%0d]: got %h expected %h", i, ww[i], exp_win5(i));
      end
    end
    checks++;
    if (ndone + post_done != 1 || post_busy != 0) begin
      errors++; $display("FAIL id_done: got done=%0d busy_after=%0d expected 1/0", ndone + post_done, post_busy);
    end
  endtask

  task automatic test_backpressure();
    run5(K_ID, 1, 5, 1'b0);
    checks++;
    if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_seen); end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL bp_held: got %0d unstable cycles expected 0", held_bad); end
    checks++;
    if (cyc_done != 79) begin errors++; $display("FAIL bp_cycles: got %0d expected 79", cyc_done); end
    checks++;
    if (timeout || nw != 6) begin errors++; $display("FAIL bp_nwrites: got %0d expected 6", nw); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wa[i] !== 16'(i) || wd[i] !== exp_data5(i)) begin
        errors++;
        $display("FAIL bp_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                 i, wa[i], wd[i], i, exp_data5(i));
      end
    end
  endtask

  task automatic test_reset_midrun();
    int acc, rdc, cnt, bad;
    bit fired;
    acc = 0; rdc = 0; cnt = 0; fired = 1'b0; bad = 0;
    @(negedge clk);
    bus5.kernel = K_ID; bus5.start = 1'b1; bus5.wr_ready = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    while (!fired && cnt < 200) begin
      if (bus5.wr_valid) acc++;
      else if (bus5.rd_en && acc == 1) begin
        rdc++;
        if (rdc == 3) begin rst5 = 1'b1; fired = 1'b1; end
      end
      if (!fired) begin @(negedge clk); cnt++; end
    end
    checks++;
    if (!fired) begin errors++; $display("FAIL rst_reach_fetch: pixel 2 fetch not seen"); end
    @(negedge clk);
    rst5 = 1'b0;
    checks++;
    if ({bus5.busy, bus5.done, bus5.rd_en, bus5.wr_valid} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b expected 0000",
               {bus5.busy, bus5.done, bus5.rd_en, bus5.wr_valid});
    end
    checks++;
    if (bus5.rd_addr !== 16'd0 || bus5.wr_addr !== 16'd0 || bus5.wr_data !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_addr: got rd=%0h wa=%0h wd=%0h expected 0", bus5.rd_addr,
               bus5.wr_addr, bus5.wr_data);
    end
    checks++;
    if (bus5.win_data !== 72'd0 || bus5.win_weight !== 72'd0) begin
      errors++; $display("FAIL rst_mid_win: got %h / %h expected 0", bus5.win_data, bus5.win_weight);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus5.wr_valid || bus5.busy) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad); end
    run5(K_ID, -1, 0, 1'b0);
    checks++;
    if (timeout || nw != 6 || cyc_done != 74) begin
      errors++; $display("FAIL rst_rerun: got writes=%0d cycles=%0d expected 6/74", nw, cyc_done);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wa[i] !== 16'(i) || wd[i] !== exp_data5(i)) begin
        errors++;
        $display("FAIL rst_rerun_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                 i, wa[i], wd[i], i, exp_data5(i));
      end
    end
  endtask

  task automatic test_start_ignored();
    run5(K_ID, -1, 0, 1'b1);
    checks++;
    if (timeout || nw != 6) begin errors++; $display("FAIL ign_nwrites: got %0d expected 6", nw); end
    checks++;
    if (cyc_done != 74) begin errors++; $display("FAIL ign_cycles: got %0d expected 74", cyc_done); end
    checks++;
    if (ndone + post_done != 1) begin
      errors++; $display("FAIL ign_done_count: got %0d expected 1", ndone + post_done);
    end
    checks++;
    if (post_busy != 0) begin errors++; $display("FAIL ign_busy_after: got %0d expected 0", post_busy); end
    checks++;
    if (bus5.win_weight !== K_ID) begin
      errors++; $display("FAIL ign_weight: got %h expected %h", bus5.win_weight, K_ID);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wa[i] !== 16'(i) || wd[i] !== exp_data5(i)) begin
        errors++;
        $display("FAIL ign_write[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                 i, wa[i], wd[i], i, exp_data5(i));
      end
    end
  endtask

  initial begin
    bus3.start = 1'b0; bus3.kernel = '0; bus3.wr_ready = 1'b1;
    bus5.start = 1'b0; bus5.kernel = '0; bus5.wr_ready = 1'b1;
    for (int i = 0; i < 9; i++)  mem3[i] = 8'h00;
    for (int i = 0; i < 20; i++) mem5[i] = 8'(i);

    test_reset();
    test_single_pixel();
    test_saturation();
    test_5x4_identity();
    test_backpressure();
    test_reset_midrun();
    test_start_ignored();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_sched.md
# conv3x3_sched

Sequencer for the combinational 3x3 convolution datapath (9 signed int8 data × 9 signed int8 weights → saturated int8). It walks a row-major IMG_W×IMG_H int8 feature map held in a synchronous-read SRAM and fetches the nine pixels of each 3x3 window one per cycle. It presents the packed window and a latched kernel to the datapath, then writes each saturated result to an output memory through a valid/ready port. The convolution is valid-only (no padding) and produces an (IMG_H-2)×(IMG_W-2) output map.

## Interface
- IMG_W, 8, input map width in pixels (≥3)
- IMG_H, 8, input map height in pixels (≥3)
- ADDR_W, 16, address width of input and output memories
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- kernel  in  72  weights, byte k at [8k+7:8k], k=ky*3+kx; latched on accepted start
- busy  out  1  high from the cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse after last write accepted
- rd_en  out  1  input-memory read strobe
- rd_addr  out  ADDR_W  input-memory address
- rd_data  in  8  read data, valid exactly one cycle after rd_en
- win_data  out  72  window to datapath, byte k = pixel k
- win_weight  out  72  latched kernel to datapath
- ans_in  in  8  datapath result (combinational from win_*)
- wr_valid  out  1  output write request
- wr_ready  in  1  output memory accepts when high with wr_valid
- wr_addr  out  ADDR_W  output address
- wr_data  out  8  output value

## Operation
- States: IDLE, FETCH, WAIT, CALC, WRITE, DONE.
- IDLE: start=1 → latch kernel, clear r=c=0, k=0, go FETCH. start while not IDLE is ignored.
- FETCH: rd_en=1, rd_addr=(r+k/3)*IMG_W+(c+k%3). k increments each cycle; after k=8 go WAIT.
- Data capture: the byte returned for read k is written into win_data slot k on the cycle after its read. Slot 8 is captured in WAIT.
- WAIT: rd_en=0; go CALC.
- CALC: win_data/win_weight stable; register ans_in into wr_data, wr_addr=r*(IMG_W-2)+c; go WRITE.
- WRITE: wr_valid=1, wr_addr/wr_data held stable until wr_ready=1. On acceptance, advance c, wrapping to 0 at IMG_W-2 and incrementing r. If the accepted pixel was r=IMG_H-3, c=IMG_W-3, go DONE; else k=0 and go FETCH.
- DONE: done=1 for one cycle, busy=1; next IDLE.
- win_data and win_weight retain their values between pixels and after DONE; they are only meaningful to the datapath in CALC.
- Address arithmetic is unsigned, truncated to ADDR_W; the integrator guarantees IMG_W*IMG_H ≤ 2^ADDR_W.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_valid=0, wr_addr=0, wr_data=0, win_data=0, win_weight=0; state IDLE.
- Reset mid-run: all of the above take effect on the next edge; an in-flight write is dropped, with no wr_valid after rst.
- Per-pixel minimum: 9 FETCH + 1 WAIT + 1 CALC + 1 WRITE = 12 cycles; each wr_ready-low cycle in WRITE adds one.
- Full run with wr_ready tied high: 12·(IMG_W-2)(IMG_H-2) + 2 cycles, counted from the start edge to the DONE cycle inclusive.
- start arriving in the same cycle as the DONE pulse is ignored; start is accepted from IDLE only.
- wr_valid never deasserts before acceptance. No read is issued outside FETCH.

## Test plan
- 3x3 map all 0x10, kernel all 0x10 → exactly one write: addr 0, data 9 (2304>>8), then done pulse; 14 cycles from start to DONE.
- 3x3 map all 127, kernel all 127 → data 127 (saturation path), one write; map all -128, kernel all 127 → data -128.
- 5×4 map (IMG_W=5, IMG_H=4), pixel value = index, identity kernel (center 0x7F, others 0) → 6 writes at addr 0..5 in order. Check the rd_addr sequence for the first pixel is 0,1,2,5,6,7,10,11,12, and all data against the bench model.
- Backpressure: wr_ready low 5 cycles on the 2nd write → wr_valid, wr_addr and wr_data held constant; the run is 5 cycles longer; results unchanged.
- Reset asserted during FETCH of pixel 2 → next cycle all outputs at reset values, busy=0. A fresh start then reproduces the full correct output sequence.
- start pulsed while busy and in the DONE cycle → ignored; kernel unchanged mid-run; exactly one done pulse per accepted start.
